// File: rtl/noc_ring_out_arb.sv
`default_nettype none
// ============================================================================
//  Module      : noc_ring_out_arb
//  Description : Ring-router output port. Round-robin arbitration of NumIn
//                input channels onto one link, with a wormhole lock held
//                from the head flit to the tail flit. Downstream flow
//                control is credit based, or ack/nack with one flit
//                outstanding.
//  Option      : define NOC_OUT_ARB_ERR_CHECK_EN to add the sticky 'err'
//                output. It flags a credit overflow or a lost tail.
//  Revision    : 1.0 - initial release
// ============================================================================

package noc_ring_out_arb_pkg;
  typedef enum logic {
    kFlowControlCreditBased = 1'b0,
    kFlowControlAckNack     = 1'b1
  } noc_flow_control_t;
endpackage

module noc_ring_out_arb
  import noc_ring_out_arb_pkg::*;
#(
  parameter int                NumIn       = 3,
  parameter int                FlitWidth   = 66,
  parameter int                CreditDepth = 4,
  parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
  localparam int               OwnerW      = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int               CreditW     = $clog2(CreditDepth + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumIn*FlitWidth-1:0] in_data,
  input  logic [NumIn-1:0]           in_valid,
  output logic [NumIn-1:0]           in_ready,
  output logic [FlitWidth-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_credit,
  output logic                       locked,
  output logic [OwnerW-1:0]          owner,
  output logic [CreditW-1:0]         credits
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
  ,
  output logic                       err
`endif
);

  // In ack/nack mode only one flit may be outstanding.
  localparam logic [CreditW-1:0] CMax =
    (FlowControl == kFlowControlCreditBased) ? CreditW'(CreditDepth) : CreditW'(1);

  typedef enum logic {StIdle = 1'b0, StLocked = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [OwnerW-1:0]     owner_q, owner_d;
  logic [OwnerW-1:0]     rr_q, rr_d;
  logic [CreditW-1:0]    credits_q, credits_d;
  logic [FlitWidth-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [OwnerW-1:0]     win;
  logic                  win_found;
  logic [FlitWidth-1:0]  win_flit;
  logic                  grant;
  int                    idx;

  function automatic logic [OwnerW-1:0] wrap_inc(input logic [OwnerW-1:0] v);
    return (int'(v) == NumIn - 1) ? '0 : v + 1'b1;
  endfunction

  // Winner selection: the locked owner, or the first head flit at or after rr.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    if (state_q == StLocked) begin
      win       = owner_q;
      win_found = in_valid[owner_q];
    end else begin
      for (int k = 0; k < NumIn; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NumIn) idx = idx - NumIn;
        if (!win_found && in_valid[idx] && in_data[idx*FlitWidth + FlitWidth - 1]) begin
          win       = OwnerW'(idx);
          win_found = 1'b1;
        end
      end
    end
    win_flit = in_data[int'(win)*FlitWidth +: FlitWidth];
  end

  // Grant, next-state, output register and credit update.
  always_comb begin
    grant       = win_found && (credits_q != '0);
    in_ready    = '0;
    if (grant) in_ready[win] = 1'b1;

    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    out_data_d  = out_data_q;
    out_valid_d = grant;

    if (grant) begin
      out_data_d = win_flit;
      if (state_q == StIdle) begin
        if (win_flit[FlitWidth-2]) begin
          rr_d = wrap_inc(win);
        end else begin
          state_d = StLocked;
          owner_d = win;
        end
      end else if (win_flit[FlitWidth-2]) begin
        state_d = StIdle;
        rr_d    = wrap_inc(owner_q);
      end
    end

    // A send and a returned credit in the same cycle cancel out; a return
    // at the maximum count is dropped.
    credits_d = credits_q;
    if (grant && !out_credit) begin
      credits_d = credits_q - 1'b1;
    end else if (!grant && out_credit && (credits_q != CMax)) begin
      credits_d = credits_q + 1'b1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_q        <= '0;
      credits_q   <= CMax;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      credits_q   <= credits_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == StLocked);
  assign owner     = owner_q;
  assign credits   = credits_q;

`ifdef NOC_OUT_ARB_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky error: credit overflow, or a new head from the owner mid-packet.
  always_comb begin
    err_d = err_q
          | (out_credit && (credits_q == CMax))
          | (grant && (state_q == StLocked) && win_flit[FlitWidth-1]);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_ring_out_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_ring_out_arb
//  Description : Directed bench for noc_ring_out_arb, with one credit-mode
//                instance and one ack/nack instance. Expected flits are
//                queued when a grant is expected. The monitors pop and
//                compare them when out_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_ring_out_arb;
  import noc_ring_out_arb_pkg::*;

  logic         clk;
  logic         rst;

  logic [197:0] in_data;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [65:0]  out_data;
  logic         out_valid;
  logic         out_credit;
  logic         locked;
  logic [1:0]   owner;
  logic [2:0]   credits;

  logic [197:0] an_in_data;
  logic [2:0]   an_in_valid;
  logic [2:0]   an_in_ready;
  logic [65:0]  an_out_data;
  logic         an_out_valid;
  logic         an_out_credit;
  logic         an_locked;
  logic [1:0]   an_owner;
  logic [2:0]   an_credits;
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
  logic         err;
  logic         an_err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [65:0] exp_q[$];
  logic [65:0] an_exp_q[$];

  noc_ring_out_arb #(
    .NumIn(3), .FlitWidth(66), .CreditDepth(4), .FlowControl(kFlowControlCreditBased)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_credit(out_credit),
    .locked(locked), .owner(owner), .credits(credits)
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
    , .err(err)
`endif
  );

  noc_ring_out_arb #(
    .NumIn(3), .FlitWidth(66), .CreditDepth(4), .FlowControl(kFlowControlAckNack)
  ) dut_an (
    .clk(clk), .rst(rst), .in_data(an_in_data), .in_valid(an_in_valid), .in_ready(an_in_ready),
    .out_data(an_out_data), .out_valid(an_out_valid), .out_credit(an_out_credit),
    .locked(an_locked), .owner(an_owner), .credits(an_credits)
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
    , .err(an_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] mk(input logic h, input logic t, input logic [63:0] p);
    return {h, t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [65:0] f);
    in_valid[ch]           = v;
    in_data[ch*66 +: 66]   = f;
  endtask

  // Scoreboard monitor for the credit-mode instance.
  initial begin
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {62'd0, out_data}, 128'h0);
          if (out_data == 66'd0) begin
            miscompares++;
            $display("FAIL unexpected_out_valid: got out_valid=1 required 0");
          end
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
      end
    end
  end

  // Scoreboard monitor for the ack/nack instance.
  initial begin
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (an_out_valid) begin
        vectors++;
        if (an_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL an_unexpected_out_valid: got out_valid=1 required 0");
        end else begin
          e = an_exp_q.pop_front();
          if (an_out_data !== e) begin
            miscompares++;
            $display("FAIL an_out_data: got %0h required %0h", an_out_data, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_data = '0; in_valid = '0; out_credit = 1'b0;
    an_in_data = '0; an_in_valid = '0; an_out_credit = 1'b0;

    // Reset values.
    tick(); tick();
    chk("rst_credits", credits, 3'd4);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 66'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_in_ready", in_ready, 3'b000);
    chk("rst_an_credits", an_credits, 3'd1);
    rst = 1'b1;
    tick();

    // Single-flit packets on all channels: grants 0,1,2,0.
    for (int c = 0; c < 4; c++) begin
      for (int ch = 0; ch < 3; ch++) set_ch(ch, 1'b1, mk(1'b1, 1'b1, 64'(ch*16 + c)));
      out_credit = (c != 0);
      #1;
      if (c != 0) chk("rr_credits", credits, 3'd3);
      chk("rr_in_ready", in_ready, 3'b001 << (c % 3));
      exp_q.push_back(mk(1'b1, 1'b1, 64'((c % 3)*16 + c)));
      tick();
    end
    in_valid = '0; out_credit = 1'b1;
    #1;
    chk("rr_idle_in_ready", in_ready, 3'b000);
    chk("rr_idle_credits", credits, 3'd3);
    tick();
    out_credit = 1'b0;
    #1;
    chk("rr_restored_credits", credits, 3'd4);

    // Wormhole: ch1 3-flit packet while ch0 offers heads (rr is 1 here).
    set_ch(0, 1'b1, mk(1'b1, 1'b1, 64'hA0));
    set_ch(1, 1'b1, mk(1'b1, 1'b0, 64'hB0));
    #1;
    chk("wh_head_ready", in_ready, 3'b010);
    chk("wh_head_unlocked", locked, 1'b0);
    exp_q.push_back(mk(1'b1, 1'b0, 64'hB0));
    tick();
    set_ch(1, 1'b0, mk(1'b0, 1'b0, 64'hB1));
    #1;
    chk("wh_locked", locked, 1'b1);
    chk("wh_owner", owner, 2'd1);
    chk("wh_owner_gap_ready", in_ready, 3'b000);
    chk("wh_credits3", credits, 3'd3);
    tick();
    set_ch(1, 1'b1, mk(1'b0, 1'b0, 64'hB1));
    #1;
    chk("wh_body_ready", in_ready, 3'b010);
    exp_q.push_back(mk(1'b0, 1'b0, 64'hB1));
    tick();
    set_ch(1, 1'b1, mk(1'b0, 1'b1, 64'hB2));
    #1;
    chk("wh_tail_ready", in_ready, 3'b010);
    chk("wh_credits2", credits, 3'd2);
    exp_q.push_back(mk(1'b0, 1'b1, 64'hB2));
    tick();
    set_ch(1, 1'b0, '0);
    #1;
    chk("wh_unlocked", locked, 1'b0);
    chk("wh_after_tail_ready", in_ready, 3'b001);
    chk("wh_credits1", credits, 3'd1);
    exp_q.push_back(mk(1'b1, 1'b1, 64'hA0));
    tick();
    // Body flit on ch2 in IDLE is never granted while credits return.
    set_ch(0, 1'b0, '0);
    set_ch(2, 1'b1, mk(1'b0, 1'b0, 64'hC0));
    out_credit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("body_ignored_ready", in_ready, 3'b000);
      chk("credit_return", credits, 3'(i));
      tick();
    end
    out_credit = 1'b0;
    set_ch(2, 1'b0, '0);
    #1;
    chk("credits_full", credits, 3'd4);

    // Credit exhaustion: 4 of 6 accepted, then one grant per returned credit.
    for (int i = 0; i < 6; i++) begin
      set_ch(0, 1'b1, mk(1'b1, 1'b1, 64'(8'hD0 + ((i < 4) ? i : 4))));
      #1;
      chk("exh_credits", credits, (i < 4) ? 3'(4 - i) : 3'd0);
      chk("exh_in_ready", in_ready, (i < 4) ? 3'b001 : 3'b000);
      if (i < 4) exp_q.push_back(mk(1'b1, 1'b1, 64'(8'hD0 + i)));
      tick();
    end
    out_credit = 1'b1;
    #1;
    chk("exh_zero_credit_ready", in_ready, 3'b000);
    tick();
    out_credit = 1'b0;
    #1;
    chk("exh_one_credit", credits, 3'd1);
    chk("exh_regrant", in_ready, 3'b001);
    exp_q.push_back(mk(1'b1, 1'b1, 64'hD4));
    tick();
    set_ch(0, 1'b0, '0);
    out_credit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("exh_return", credits, 3'(i));
      tick();
    end
    out_credit = 1'b0;
    #1;
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
    chk("err_clear", err, 1'b0);
`endif
    // Return at the maximum count saturates.
    out_credit = 1'b1;
    #1;
    chk("sat_before", credits, 3'd4);
    tick();
    out_credit = 1'b0;
    #1;
    chk("sat_after", credits, 3'd4);
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
    chk("err_overflow", err, 1'b1);
    tick();
    chk("err_sticky", err, 1'b1);
`endif

    // Ack/nack: 2-flit packet on ch2, one flit outstanding.
    an_in_valid[2] = 1'b1; an_in_data[132 +: 66] = mk(1'b1, 1'b0, 64'hE0);
    #1;
    chk("an_head_ready", an_in_ready, 3'b100);
    chk("an_credits1", an_credits, 3'd1);
    an_exp_q.push_back(mk(1'b1, 1'b0, 64'hE0));
    tick();
    an_in_data[132 +: 66] = mk(1'b0, 1'b1, 64'hE1);
    #1;
    chk("an_locked", an_locked, 1'b1);
    chk("an_owner", an_owner, 2'd2);
    chk("an_blocked", an_in_ready, 3'b000);
    chk("an_credits0", an_credits, 3'd0);
    tick();
    an_out_credit = 1'b1;
    #1;
    chk("an_ack_cycle_blocked", an_in_ready, 3'b000);
    tick();
    an_out_credit = 1'b0;
    #1;
    chk("an_tail_ready", an_in_ready, 3'b100);
    an_exp_q.push_back(mk(1'b0, 1'b1, 64'hE1));
    tick();
    an_in_valid = '0;
    #1;
    chk("an_idle", an_locked, 1'b0);
    chk("an_after_tail_credits", an_credits, 3'd0);
    an_out_credit = 1'b1;
    tick();
    an_out_credit = 1'b0;
    #1;
    chk("an_restored", an_credits, 3'd1);

    // Reset clears err; head from the owner while locked; reset mid-packet.
    @(negedge clk); #1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
    chk("err_reset", err, 1'b0);
`endif
    set_ch(0, 1'b1, mk(1'b1, 1'b0, 64'hF0));
    #1;
    chk("lt_head_ready", in_ready, 3'b001);
    exp_q.push_back(mk(1'b1, 1'b0, 64'hF0));
    tick();
    set_ch(0, 1'b1, mk(1'b1, 1'b1, 64'hF1));
    #1;
    chk("lt_locked", locked, 1'b1);
    chk("lt_head_in_lock_ready", in_ready, 3'b001);
    exp_q.push_back(mk(1'b1, 1'b1, 64'hF1));
    tick();
    set_ch(0, 1'b1, mk(1'b1, 1'b0, 64'hF2));
    #1;
    chk("lt_unlocked", locked, 1'b0);
`ifdef NOC_OUT_ARB_ERR_CHECK_EN
    chk("err_lost_tail", err, 1'b1);
`endif
    exp_q.push_back(mk(1'b1, 1'b0, 64'hF2));
    tick();
    set_ch(0, 1'b0, '0);
    #1;
    chk("mid_locked", locked, 1'b1);
    chk("mid_credits", credits, 3'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_credits", credits, 3'd4);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    tick();
    rst = 1'b1;
    tick(); tick();

    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    chk("an_exp_q_drained", 128'(an_exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
